dbus_bridge: RTL
================

# dbus_bridge

Multi-cycle data-bus bridge between the LSU stage and the data memory / MMIO fabric. It latches the LSU's combinational single-cycle dbus request and replays it as a valid/ready request plus a response handshake. It holds the pipeline through `O_stallreq` until the response returns, then presents the full 32-bit read word back to the LSU, which does the byte/halfword extraction. It also detects hung transactions with a timeout counter.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: cycles allowed in REQ+RESP before abort. 0 disables the timeout.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `I_dbus_req`  in  1  LSU access request. Level signal, held stable while stalled.
- `I_dbus_we`  in  1  1 = store, 0 = load.
- `I_dbus_addr`  in  32  byte address, forwarded unmodified.
- `I_dbus_data`  in  32  pre-aligned store data.
- `I_dbus_mask`  in  4  byte strobes.
- `O_dbus_data`  out  32  read word returned to the LSU.
- `O_stallreq`  out  1  pipeline stall request.
- `I_hold`  in  1  pipeline frozen by another stage; the LSU inputs stay the same next cycle.
- `I_flush`  in  1  squash the instruction currently in the LSU.
- `O_mem_valid`  out  1  request valid.
- `I_mem_ready`  in  1  request accepted.
- `O_mem_we`  out  1  registered copy of `I_dbus_we`.
- `O_mem_addr`  out  32  registered copy of `I_dbus_addr`.
- `O_mem_wdata`  out  32  registered copy of `I_dbus_data`.
- `O_mem_wstrb`  out  4  registered copy of `I_dbus_mask`.
- `I_mem_rvalid`  in  1  response valid. Used for both load data and store acknowledge.
- `I_mem_rdata`  in  32  response data. Ignored for stores.
- `O_mem_rready`  out  1  ready to accept the response.
- `O_bus_err`  out  1  one-cycle pulse when a transaction times out.

## Operation
States: IDLE, REQ, RESP, DONE.

- IDLE:
  - If `I_dbus_req && !I_flush`: capture we/addr/data/mask into the request registers and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `O_mem_valid=1`.
  - On `I_mem_ready`, go to RESP.
  - `I_mem_rvalid` seen in this state is dropped (stale response).
- RESP:
  - `O_mem_rready=1`.
  - On `I_mem_rvalid`, capture `I_mem_rdata` into `rdata_q` (stores capture 0) and go to DONE.
- DONE:
  - `O_dbus_data=rdata_q`.
  - If `I_hold=1`, stay in DONE; the same instruction must not be re-issued.
  - Otherwise go to IDLE.
- `O_stallreq` = (IDLE && `I_dbus_req` && !`I_flush`) || REQ || RESP. It is 0 in DONE, so the pipeline advances on that edge.
- Flush:
  - `I_flush` in REQ/RESP does not abort the bus transaction; it completes normally.
  - A `flushed_q` flag is set. On reaching DONE the bridge goes straight to IDLE, ignoring `I_hold`, and `rdata_q` is unused.
  - `O_stallreq` stays 1 until the transaction completes.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ/RESP.
  - When it reaches `TIMEOUT_CYC` (nonzero): go to DONE, `rdata_q=0`, `O_bus_err=1` for that one cycle.
  - Counter width is `$clog2(TIMEOUT_CYC+1)`, minimum 1.
- The request registers are loaded only on the IDLE→REQ transition. The `O_mem_*` outputs are constant from REQ through DONE.

## Timing
- Reset values (asynchronous, on `rst=0`):
  - state IDLE, rdata_q 0, counter 0, `flushed_q` 0.
  - All `O_mem_*` 0, `O_bus_err` 0, `O_dbus_data` 0.
  - `O_stallreq` follows its equation, so it is 0 unless a request is present.
- Reset mid-transaction returns to IDLE immediately. The outstanding fabric transaction is abandoned; the fabric is reset together with the bridge.
- Best case (ready in REQ's first cycle, rvalid in RESP's first cycle): the request is seen in cycle 0 and the state is DONE in cycle 3.
  - `O_stallreq` is high in cycles 0–2, low in cycle 3.
  - Load result is valid in cycle 3.
- Each cycle `I_mem_ready` is late adds one cycle; likewise each cycle `I_mem_rvalid` is late.
- `O_mem_valid` must not drop once asserted until `I_mem_ready`.
- At most one outstanding transaction.

## Structure
- Bus widths come from the existing shared defines (`MemAddrBus`, `MemDataBus`, `DBUS_MASK`).
- Add the state encoding (`DBR_IDLE`/`REQ`/`RESP`/`DONE`, 2 bits) to the shared defines file.
- Single flat module, no sub-modules; the timeout counter is inline.

## Test plan
- Load, addr 0x8000_0004, ready=1 immediately, rvalid next cycle with rdata 0xDEAD_BEEF:
  - Stall high for 3 cycles.
  - `O_dbus_data`=0xDEAD_BEEF in DONE.
- Store sb, addr 0x8000_0003, mask 4'b1000, data 0xAB00_0000, ready delayed 2 cycles:
  - `O_mem_valid` held for 3 cycles.
  - `O_mem_wstrb`=1000.
  - Stall lasts 5 cycles.
- Load completes with `I_hold`=1 for 3 cycles:
  - Bridge stays in DONE.
  - Exactly one `O_mem_valid` handshake total, no re-issue.
- `TIMEOUT_CYC`=8, ready never asserted:
  - At cycle 8 after REQ entry, `O_bus_err` pulses once.
  - `O_dbus_data`=0, stall drops, bridge back in IDLE next cycle.
- `I_flush` asserted in RESP:
  - Transaction completes.
  - DONE exits to IDLE despite `I_hold`=1.
  - No second request.
- `rst` driven low in RESP:
  - All outputs 0 asynchronously.
  - A new request after reset issues normally.

Source files
------------

// File: rtl/dbus_bridge_pkg.sv
// Shared bus widths, bridge state encoding and request record for the LSU data-bus bridge.
package dbus_bridge_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemDataBus = 32;
    localparam int DBUS_MASK  = 4;

    typedef enum logic [1:0] {
        DBR_IDLE = 2'd0,
        DBR_REQ  = 2'd1,
        DBR_RESP = 2'd2,
        DBR_DONE = 2'd3
    } dbr_state_t;

    typedef struct packed {
        logic                  we;
        logic [MemAddrBus-1:0] addr;
        logic [MemDataBus-1:0] wdata;
        logic [DBUS_MASK-1:0]  wstrb;
    } dbr_req_t;

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int dbr_cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/dbus_bridge.sv
// LSU dbus bridge: latches a single-cycle request, replays it as valid/ready + response handshake, stalls the pipe until done.
// Best case 3 cycles of stall; each late ready/rvalid adds one; I_hold parks the result in DONE; one transaction outstanding.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I_dbus_req,
    input  logic                  I_dbus_we,
    input  logic [MemAddrBus-1:0] I_dbus_addr,
    input  logic [MemDataBus-1:0] I_dbus_data,
    input  logic [DBUS_MASK-1:0]  I_dbus_mask,
    output logic [MemDataBus-1:0] O_dbus_data,
    output logic                  O_stallreq,
    input  logic                  I_hold,
    input  logic                  I_flush,
    output logic                  O_mem_valid,
    input  logic                  I_mem_ready,
    output logic                  O_mem_we,
    output logic [MemAddrBus-1:0] O_mem_addr,
    output logic [MemDataBus-1:0] O_mem_wdata,
    output logic [DBUS_MASK-1:0]  O_mem_wstrb,
    input  logic                  I_mem_rvalid,
    input  logic [MemDataBus-1:0] I_mem_rdata,
    output logic                  O_mem_rready,
    output logic                  O_bus_err
);

    localparam int            CW     = dbr_cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);
    localparam bit            TO_EN  = (TIMEOUT_CYC > 0);

    dbr_state_t            state;
    dbr_req_t              req_q;
    logic [MemDataBus-1:0] rdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  flushed_q;
    logic                  bus_err_q;

    logic                  start;
    logic                  busy;
    logic                  timeout_hit;
    logic [CW-1:0]         cnt_inc;

    assign start   = (state == DBR_IDLE) && I_dbus_req && !I_flush;
    assign busy    = (state == DBR_REQ) || (state == DBR_RESP);
    assign cnt_inc = cnt_q + CW'(1);

    // Fires on the last allowed REQ/RESP cycle so DONE lands exactly TIMEOUT_CYC cycles after REQ entry.
    assign timeout_hit = TO_EN && busy && (cnt_inc == TO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DBR_IDLE;
            req_q     <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            unique case (state)
                DBR_IDLE: begin
                    if (start) begin
                        state       <= DBR_REQ;
                        req_q.we    <= I_dbus_we;
                        req_q.addr  <= I_dbus_addr;
                        req_q.wdata <= I_dbus_data;
                        req_q.wstrb <= I_dbus_mask;
                        cnt_q       <= '0;
                        flushed_q   <= 1'b0;
                    end
                end
                DBR_REQ: begin
                    cnt_q <= cnt_inc;
                    if (I_flush) begin
                        flushed_q <= 1'b1;
                    end
                    // Responses arriving before acceptance are stale and dropped.
                    if (timeout_hit) begin
                        state     <= DBR_DONE;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else if (I_mem_ready) begin
                        state <= DBR_RESP;
                    end
                end
                DBR_RESP: begin
                    cnt_q <= cnt_inc;
                    if (I_flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (timeout_hit) begin
                        state     <= DBR_DONE;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else if (I_mem_rvalid) begin
                        state   <= DBR_DONE;
                        rdata_q <= req_q.we ? '0 : I_mem_rdata;
                    end
                end
                DBR_DONE: begin
                    // A squashed instruction must not park the bridge behind a pipeline hold.
                    if (flushed_q || !I_hold) begin
                        state     <= DBR_IDLE;
                        flushed_q <= 1'b0;
                    end
                end
                default: state <= DBR_IDLE;
            endcase
        end
    end

    assign O_stallreq   = start || busy;
    assign O_mem_valid  = (state == DBR_REQ);
    assign O_mem_rready = (state == DBR_RESP);
    assign O_mem_we     = req_q.we;
    assign O_mem_addr   = req_q.addr;
    assign O_mem_wdata  = req_q.wdata;
    assign O_mem_wstrb  = req_q.wstrb;
    assign O_dbus_data  = rdata_q;
    assign O_bus_err    = bus_err_q;

endmodule
